fpu_ss_wb_arbiter: RTL and testbench

Writeback arbiter and result sequencer for the FPU subsystem. It merges two completion sources, the FPNew result port (tagged with `fpu_tag_t`) and the load/store completion path (tagged with `mem_metadata_t`). For each completion it writes the FP register file, accumulates `fflags`, and emits exactly one cv-x-if `x_result_t` transaction per offloaded instruction through a registered output stage. It sits between the FPU/LSU datapaths and the core's X-interface result channel.

---
 rtl/fpu_ss_pkg.sv | 53 +++++
 rtl/fpu_ss_wb_rr.sv | 47 ++++
 rtl/fpu_ss_wb_arbiter.sv | 126 ++++++++++++
 tb/tb_fpu_ss_wb_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_ss_pkg.sv
// ============================================================================
// fpu_ss_pkg: shared types and constants for the FPU subsystem writeback path.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fpu_ss_pkg;

    localparam int FLEN        = 32;
    localparam int X_ID_WIDTH  = 4;
    localparam int X_RFW_WIDTH = 32;

    typedef enum logic {
        WbFpu = 1'b0,
        WbMem = 1'b1
    } wb_src_e;

    localparam logic [1:0] FS_DIRTY = 2'b11;

    // mstatus-update fields of the X-interface result: only FS is ever touched here.
    localparam logic [2:0] ECSWE_FS         = 3'b010;
    localparam logic [5:0] ECSDATA_FS_DIRTY = {2'b00, FS_DIRTY, 2'b00};

    typedef struct packed {
        logic [4:0]            addr;
        logic                  rd_is_fp;
        logic [X_ID_WIDTH-1:0] id;
    } fpu_tag_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [4:0]            rd;
        logic                  we;
    } mem_metadata_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0]  id;
        logic [X_RFW_WIDTH-1:0] data;
        logic [4:0]             rd;
        logic                   we;
        logic [2:0]             ecswe;
        logic [5:0]             ecsdata;
        logic                   exc;
        logic [5:0]             exccode;
        logic                   err;
        logic                   dbg;
    } x_result_t;

    localparam x_result_t X_RESULT_DEFAULT = '0;

endpackage

`default_nettype wire

// File: rtl/fpu_ss_wb_rr.sv
// ============================================================================
// fpu_ss_wb_rr: two-way round-robin grant between the FPU and LSU completions.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fpu_ss_wb_rr
    import fpu_ss_pkg::*;
#(
    parameter logic RR_INIT = 1'b0
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    fpu_valid_i,
    input  logic    mem_valid_i,
    input  logic    accept_i,
    output wb_src_e gnt_o
);

    logic rr_q;
    logic rr_d;

    always_comb begin
        rr_d  = rr_q;
        gnt_o = WbFpu;
        if (fpu_valid_i && mem_valid_i) begin
            gnt_o = wb_src_e'(rr_q);
        end else if (mem_valid_i) begin
            gnt_o = WbMem;
        end
        // Pointer always lands on the source that was not just served.
        if (accept_i) begin
            rr_d = (gnt_o == WbFpu) ? 1'b1 : 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_q <= RR_INIT;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fpu_ss_wb_arbiter.sv
// ============================================================================
// fpu_ss_wb_arbiter: merges FPU and LSU completions into FPR writes, fflags
// updates and one registered X-interface result per offloaded instruction.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fpu_ss_wb_arbiter
    import fpu_ss_pkg::*;
#(
    parameter int unsigned FLEN    = fpu_ss_pkg::FLEN,
    parameter logic        RR_INIT = 1'b0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            fpu_valid_i,
    output logic            fpu_ready_o,
    input  logic [FLEN-1:0] fpu_result_i,
    input  fpu_tag_t        fpu_tag_i,
    input  logic [4:0]      fpu_status_i,
    input  logic            mem_valid_i,
    output logic            mem_ready_o,
    input  logic [FLEN-1:0] mem_rdata_i,
    input  mem_metadata_t   mem_meta_i,
    output logic            fpr_we_o,
    output logic [4:0]      fpr_waddr_o,
    output logic [FLEN-1:0] fpr_wdata_o,
    output logic            fflags_we_o,
    output logic [4:0]      fflags_o,
    output logic            x_result_valid_o,
    input  logic            x_result_ready_i,
    output x_result_t       x_result_o
);

    logic      out_valid_q;
    logic      out_valid_d;
    x_result_t out_q;
    x_result_t out_d;

    logic      out_free;
    logic      accept;
    wb_src_e   gnt;
    x_result_t entry;

    fpu_ss_wb_rr #(
        .RR_INIT (RR_INIT)
    ) u_rr (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .fpu_valid_i (fpu_valid_i),
        .mem_valid_i (mem_valid_i),
        .accept_i    (accept),
        .gnt_o       (gnt)
    );

    assign out_free = !out_valid_q || x_result_ready_i;
    assign accept   = rst_ni && out_free && (fpu_valid_i || mem_valid_i);

    always_comb begin
        fpu_ready_o = 1'b0;
        mem_ready_o = 1'b0;
        fpr_we_o    = 1'b0;
        fpr_waddr_o = '0;
        fpr_wdata_o = '0;
        fflags_we_o = 1'b0;
        fflags_o    = '0;
        entry       = X_RESULT_DEFAULT;

        if (accept && gnt == WbFpu) begin
            fpu_ready_o   = 1'b1;
            fflags_we_o   = 1'b1;
            fflags_o      = fpu_status_i;
            entry.id      = fpu_tag_i.id;
            entry.ecswe   = ECSWE_FS;
            entry.ecsdata = ECSDATA_FS_DIRTY;
            if (fpu_tag_i.rd_is_fp) begin
                fpr_we_o    = 1'b1;
                fpr_waddr_o = fpu_tag_i.addr;
                fpr_wdata_o = fpu_result_i;
            end else begin
                entry.we   = 1'b1;
                entry.rd   = fpu_tag_i.addr;
                entry.data = X_RFW_WIDTH'(fpu_result_i);
            end
        end else if (accept && gnt == WbMem) begin
            mem_ready_o = 1'b1;
            entry.id    = mem_meta_i.id;
            if (mem_meta_i.we) begin
                fpr_we_o      = 1'b1;
                fpr_waddr_o   = mem_meta_i.rd;
                fpr_wdata_o   = mem_rdata_i;
                entry.ecswe   = ECSWE_FS;
                entry.ecsdata = ECSDATA_FS_DIRTY;
            end
        end
    end

    // A new acceptance overrides the drain so back-to-back results see no bubble.
    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_d       = entry;
        end else if (out_valid_q && x_result_ready_i) begin
            out_valid_d = 1'b0;
            out_d       = X_RESULT_DEFAULT;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_q       <= X_RESULT_DEFAULT;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign x_result_valid_o = out_valid_q;
    assign x_result_o       = out_q;

endmodule

`default_nettype wire

// File: tb/tb_fpu_ss_wb_arbiter.sv
// ============================================================================
// tb_fpu_ss_wb_arbiter: directed self-checking bench for fpu_ss_wb_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fpu_ss_wb_arbiter;
    import fpu_ss_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fpu_valid;
    logic          fpu_ready;
    logic [31:0]   fpu_result;
    fpu_tag_t      fpu_tag;
    logic [4:0]    fpu_status;
    logic          mem_valid;
    logic          mem_ready;
    logic [31:0]   mem_rdata;
    mem_metadata_t mem_meta;
    logic          fpr_we;
    logic [4:0]    fpr_waddr;
    logic [31:0]   fpr_wdata;
    logic          fflags_we;
    logic [4:0]    fflags;
    logic          x_valid;
    logic          x_ready;
    x_result_t     x_res;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fpu_ss_wb_arbiter #(
        .FLEN    (32),
        .RR_INIT (1'b0)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .fpu_valid_i      (fpu_valid),
        .fpu_ready_o      (fpu_ready),
        .fpu_result_i     (fpu_result),
        .fpu_tag_i        (fpu_tag),
        .fpu_status_i     (fpu_status),
        .mem_valid_i      (mem_valid),
        .mem_ready_o      (mem_ready),
        .mem_rdata_i      (mem_rdata),
        .mem_meta_i       (mem_meta),
        .fpr_we_o         (fpr_we),
        .fpr_waddr_o      (fpr_waddr),
        .fpr_wdata_o      (fpr_wdata),
        .fflags_we_o      (fflags_we),
        .fflags_o         (fflags),
        .x_result_valid_o (x_valid),
        .x_result_ready_i (x_ready),
        .x_result_o       (x_res)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_ids [4] = '{4'd1, 4'd8, 4'd2, 4'd9};
    logic       exp_fpu [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0] held_id;

    initial begin
        rst_n      = 1'b0;
        x_ready    = 1'b1;
        fpu_valid  = 1'b1;
        fpu_result = 32'h0;
        fpu_tag    = '0;
        fpu_status = 5'd0;
        mem_valid  = 1'b0;
        mem_rdata  = 32'h0;
        mem_meta   = '0;
        #1;
        check("rst_fpu_ready", 64'(fpu_ready), 64'd0);
        check("rst_fpr_we", 64'(fpr_we), 64'd0);
        step();
        step();
        fpu_valid = 1'b0;
        rst_n     = 1'b1;
        #1;
        check("rst_x_valid", 64'(x_valid), 64'd0);
        check("rst_x_res", 64'(x_res), 64'd0);

        // FPU result to FP destination
        fpu_valid  = 1'b1;
        fpu_tag    = '{addr: 5'd5, rd_is_fp: 1'b1, id: 4'd3};
        fpu_result = 32'h3F800000;
        fpu_status = 5'b00001;
        #1;
        check("f1_ready", 64'(fpu_ready), 64'd1);
        check("f1_mem_ready", 64'(mem_ready), 64'd0);
        check("f1_fpr_we", 64'(fpr_we), 64'd1);
        check("f1_waddr", 64'(fpr_waddr), 64'd5);
        check("f1_wdata", 64'(fpr_wdata), 64'h3F800000);
        check("f1_ff_we", 64'(fflags_we), 64'd1);
        check("f1_ff", 64'(fflags), 64'b00001);
        step();
        fpu_valid = 1'b0;
        check("f1_x_valid", 64'(x_valid), 64'd1);
        check("f1_id", 64'(x_res.id), 64'd3);
        check("f1_we", 64'(x_res.we), 64'd0);
        check("f1_data", 64'(x_res.data), 64'd0);
        check("f1_ecswe", 64'(x_res.ecswe), 64'b010);
        check("f1_ecsdata", 64'(x_res.ecsdata), 64'b001100);

        // FPU result to integer destination
        fpu_valid  = 1'b1;
        fpu_tag    = '{addr: 5'd10, rd_is_fp: 1'b0, id: 4'd4};
        fpu_result = 32'h00000007;
        fpu_status = 5'b10000;
        #1;
        check("f2_ready", 64'(fpu_ready), 64'd1);
        check("f2_fpr_we", 64'(fpr_we), 64'd0);
        check("f2_ff_we", 64'(fflags_we), 64'd1);
        check("f2_ff", 64'(fflags), 64'b10000);
        step();
        fpu_valid = 1'b0;
        check("f2_x_valid", 64'(x_valid), 64'd1);
        check("f2_id", 64'(x_res.id), 64'd4);
        check("f2_rd", 64'(x_res.rd), 64'd10);
        check("f2_we", 64'(x_res.we), 64'd1);
        check("f2_data", 64'(x_res.data), 64'd7);

        // Store completion; also leaves the pointer on FPU
        mem_valid = 1'b1;
        mem_meta  = '{id: 4'd9, rd: 5'd7, we: 1'b0};
        mem_rdata = 32'hDEADBEEF;
        #1;
        check("st_ready", 64'(mem_ready), 64'd1);
        check("st_fpr_we", 64'(fpr_we), 64'd0);
        check("st_ff_we", 64'(fflags_we), 64'd0);
        step();
        mem_valid = 1'b0;
        check("st_x_valid", 64'(x_valid), 64'd1);
        check("st_id", 64'(x_res.id), 64'd9);
        check("st_we", 64'(x_res.we), 64'd0);
        check("st_ecswe", 64'(x_res.ecswe), 64'd0);
        check("st_ecsdata", 64'(x_res.ecsdata), 64'd0);

        // Both sources valid every cycle: strict alternation, back-to-back results
        begin
            int fpu_n = 0;
            int mem_n = 0;
            fpu_valid = 1'b1;
            mem_valid = 1'b1;
            for (int k = 0; k < 4; k++) begin
                fpu_tag    = '{addr: 5'(k), rd_is_fp: 1'b1, id: 4'(fpu_n + 1)};
                fpu_result = 32'h40000000 + 32'(k);
                mem_meta   = '{id: 4'(mem_n + 8), rd: 5'd20, we: 1'b1};
                mem_rdata  = 32'hA0000000 + 32'(k);
                #1;
                check($sformatf("rr%0d_fpu_ready", k), 64'(fpu_ready), 64'(exp_fpu[k]));
                check($sformatf("rr%0d_mem_ready", k), 64'(mem_ready), 64'(!exp_fpu[k]));
                if (k == 1) begin
                    check("ld_fpr_we", 64'(fpr_we), 64'd1);
                    check("ld_waddr", 64'(fpr_waddr), 64'd20);
                    check("ld_wdata", 64'(fpr_wdata), 64'hA0000001);
                    check("ld_ff_we", 64'(fflags_we), 64'd0);
                end
                if (fpu_ready) fpu_n++;
                if (mem_ready) mem_n++;
                step();
                check($sformatf("rr%0d_x_valid", k), 64'(x_valid), 64'd1);
                check($sformatf("rr%0d_id", k), 64'(x_res.id), 64'(exp_ids[k]));
            end
            check("ld_ecswe", 64'(x_res.ecswe), 64'b010);
            fpu_tag  = '{addr: 5'd2, rd_is_fp: 1'b1, id: 4'd3};
            mem_meta = '{id: 4'd10, rd: 5'd21, we: 1'b1};
        end

        // Back-pressure for 3 cycles with both sources valid
        x_ready = 1'b0;
        held_id = 4'd9;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp%0d_fpu_ready", k), 64'(fpu_ready), 64'd0);
            check($sformatf("bp%0d_mem_ready", k), 64'(mem_ready), 64'd0);
            step();
            check($sformatf("bp%0d_x_valid", k), 64'(x_valid), 64'd1);
            check($sformatf("bp%0d_id", k), 64'(x_res.id), 64'(held_id));
        end
        x_ready = 1'b1;
        #1;
        check("rel_fpu_ready", 64'(fpu_ready), 64'd1);
        check("rel_mem_ready", 64'(mem_ready), 64'd0);
        step();
        fpu_valid = 1'b0;
        check("rel_x_valid", 64'(x_valid), 64'd1);
        check("rel_id", 64'(x_res.id), 64'd3);
        #1;
        check("rel2_mem_ready", 64'(mem_ready), 64'd1);
        step();
        mem_valid = 1'b0;
        check("rel2_id", 64'(x_res.id), 64'd10);

        // FPU-only accept moves the pointer to MEM, then reset mid-transaction
        fpu_valid = 1'b1;
        fpu_tag   = '{addr: 5'd1, rd_is_fp: 1'b1, id: 4'd5};
        step();
        check("pre_rst_id", 64'(x_res.id), 64'd5);
        x_ready = 1'b0;
        rst_n   = 1'b0;
        #1;
        check("inrst_fpr_we", 64'(fpr_we), 64'd0);
        check("inrst_fpu_ready", 64'(fpu_ready), 64'd0);
        step();
        check("postrst_x_valid", 64'(x_valid), 64'd0);
        check("postrst_x_res", 64'(x_res), 64'd0);
        rst_n     = 1'b1;
        x_ready   = 1'b1;
        mem_valid = 1'b1;
        mem_meta  = '{id: 4'd11, rd: 5'd3, we: 1'b1};
        #1;
        check("postrst_rr_fpu", 64'(fpu_ready), 64'd1);
        check("postrst_rr_mem", 64'(mem_ready), 64'd0);
        step();
        fpu_valid = 1'b0;
        mem_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
